// File: rtl/pic_exec_unit_pkg.sv
// Shared definitions for the PIC16C57 execute stage.
// Holds register-file write command encodings, Q-phase encodings, STATUS bit
// indices, opcode mask/value pairs, the ALU operation classes and the
// instruction decoder used by pic_exec_unit.
package pic_exec_unit_pkg;

  localparam int PIC_DATA_WIDTH = 8;
  localparam int PIC_INST_WIDTH = 12;

  // Register file write commands
  localparam logic [2:0] RF_WR________NOP = 3'd0;  // no write
  localparam logic [2:0] RF_WR_____STATUS = 3'd1;  // STATUS only
  localparam logic [2:0] RF_WR_FSR____IND = 3'd2;  // file register only
  localparam logic [2:0] RF_WR_FSR_STATUS = 3'd3;  // file register and STATUS

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} qphase_e;

  // STATUS bit indices
  localparam int ST_C  = 0;
  localparam int ST_DC = 1;
  localparam int ST_Z  = 2;

  // Flag-update masks, bit positions follow the STATUS indices
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_C    = 3'b001;
  localparam logic [2:0] FL_Z    = 3'b100;
  localparam logic [2:0] FL_CDZ  = 3'b111;

  localparam logic [PIC_INST_WIDTH-1:0] INST_NOP = '0;

  // Opcode field masks
  localparam logic [11:0] M_FULL   = 12'hFFF;
  localparam logic [11:0] M_OPTSLP = 12'hFFE;  // OPTION / SLEEP
  localparam logic [11:0] M_TRIS   = 12'hFFC;  // CLRWDT and TRIS 5..7
  localparam logic [11:0] M_FILE7  = 12'hFE0;  // MOVWF / CLRF
  localparam logic [11:0] M_BYTE   = 12'hFC0;  // byte-oriented ops with d bit
  localparam logic [11:0] M_GRP    = 12'hF00;  // bit ops and literal ops
  localparam logic [11:0] M_GOTO   = 12'hE00;

  // Opcode values
  localparam logic [11:0] V_OPTSLP = 12'h002;
  localparam logic [11:0] V_TRIS   = 12'h004;
  localparam logic [11:0] V_MOVWF  = 12'h020;
  localparam logic [11:0] V_CLRW   = 12'h040;
  localparam logic [11:0] V_CLRF   = 12'h060;
  localparam logic [11:0] V_SUBWF  = 12'h080;
  localparam logic [11:0] V_DECF   = 12'h0C0;
  localparam logic [11:0] V_IORWF  = 12'h100;
  localparam logic [11:0] V_ANDWF  = 12'h140;
  localparam logic [11:0] V_XORWF  = 12'h180;
  localparam logic [11:0] V_ADDWF  = 12'h1C0;
  localparam logic [11:0] V_MOVF   = 12'h200;
  localparam logic [11:0] V_COMF   = 12'h240;
  localparam logic [11:0] V_INCF   = 12'h280;
  localparam logic [11:0] V_DECFSZ = 12'h2C0;
  localparam logic [11:0] V_RRF    = 12'h300;
  localparam logic [11:0] V_RLF    = 12'h340;
  localparam logic [11:0] V_SWAPF  = 12'h380;
  localparam logic [11:0] V_INCFSZ = 12'h3C0;
  localparam logic [11:0] V_BCF    = 12'h400;
  localparam logic [11:0] V_BSF    = 12'h500;
  localparam logic [11:0] V_BTFSC  = 12'h600;
  localparam logic [11:0] V_BTFSS  = 12'h700;
  localparam logic [11:0] V_RETLW  = 12'h800;
  localparam logic [11:0] V_CALL   = 12'h900;
  localparam logic [11:0] V_GOTO   = 12'hA00;
  localparam logic [11:0] V_MOVLW  = 12'hC00;
  localparam logic [11:0] V_IORLW  = 12'hD00;
  localparam logic [11:0] V_ANDLW  = 12'hE00;
  localparam logic [11:0] V_XORLW  = 12'hF00;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_MOVWF, ALU_CLR, ALU_SUB, ALU_DEC, ALU_IOR, ALU_AND,
    ALU_XOR, ALU_ADD, ALU_MOVF, ALU_COMF, ALU_INC, ALU_DECFSZ, ALU_RRF,
    ALU_RLF, ALU_SWAP, ALU_INCFSZ, ALU_BCF, ALU_BSF, ALU_BTFSC, ALU_BTFSS,
    ALU_MOVLW, ALU_IORLW, ALU_ANDLW, ALU_XORLW
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic       wr_f;   // result goes to file register
    logic       wr_w;   // result goes to W
    logic [2:0] flg;    // STATUS bits this op updates
    logic       unsup;  // opcode not executed by this stage
  } dec_t;

  function automatic logic op_is(input logic [11:0] inst, input logic [11:0] m,
                                 input logic [11:0] v);
    return (inst & m) == v;
  endfunction

  function automatic dec_t decode(input logic [PIC_INST_WIDTH-1:0] inst);
    dec_t d;
    logic df;
    logic [11:0] bop;
    df  = inst[5];
    bop = inst & M_BYTE;
    d   = '{op: ALU_NOP, wr_f: 1'b0, wr_w: 1'b0, flg: FL_NONE, unsup: 1'b0};
    if (op_is(inst, M_FULL, V_CLRW)) begin
      d.op = ALU_CLR; d.wr_w = 1'b1; d.flg = FL_Z;
    end else if (op_is(inst, M_FILE7, V_MOVWF)) begin
      d.op = ALU_MOVWF; d.wr_f = 1'b1;
    end else if (op_is(inst, M_FILE7, V_CLRF)) begin
      d.op = ALU_CLR; d.wr_f = 1'b1; d.flg = FL_Z;
    end else if (op_is(inst, M_OPTSLP, V_OPTSLP) || op_is(inst, M_TRIS, V_TRIS) ||
                 op_is(inst, M_GRP, V_RETLW) || op_is(inst, M_GRP, V_CALL) ||
                 op_is(inst, M_GOTO, V_GOTO)) begin
      d.unsup = 1'b1;
    end else if (bop >= V_SUBWF && bop <= V_INCFSZ) begin
      d.wr_f = df;
      d.wr_w = !df;
      unique case (bop)
        V_SUBWF:  begin d.op = ALU_SUB;    d.flg = FL_CDZ; end
        V_DECF:   begin d.op = ALU_DEC;    d.flg = FL_Z;   end
        V_IORWF:  begin d.op = ALU_IOR;    d.flg = FL_Z;   end
        V_ANDWF:  begin d.op = ALU_AND;    d.flg = FL_Z;   end
        V_XORWF:  begin d.op = ALU_XOR;    d.flg = FL_Z;   end
        V_ADDWF:  begin d.op = ALU_ADD;    d.flg = FL_CDZ; end
        V_MOVF:   begin d.op = ALU_MOVF;   d.flg = FL_Z;   end
        V_COMF:   begin d.op = ALU_COMF;   d.flg = FL_Z;   end
        V_INCF:   begin d.op = ALU_INC;    d.flg = FL_Z;   end
        V_DECFSZ: d.op = ALU_DECFSZ;
        V_RRF:    begin d.op = ALU_RRF;    d.flg = FL_C;   end
        V_RLF:    begin d.op = ALU_RLF;    d.flg = FL_C;   end
        V_SWAPF:  d.op = ALU_SWAP;
        V_INCFSZ: d.op = ALU_INCFSZ;
        default:  begin d.wr_f = 1'b0; d.wr_w = 1'b0; end
      endcase
    end else if (op_is(inst, M_GRP, V_BCF)) begin
      d.op = ALU_BCF; d.wr_f = 1'b1;
    end else if (op_is(inst, M_GRP, V_BSF)) begin
      d.op = ALU_BSF; d.wr_f = 1'b1;
    end else if (op_is(inst, M_GRP, V_BTFSC)) begin
      d.op = ALU_BTFSC;
    end else if (op_is(inst, M_GRP, V_BTFSS)) begin
      d.op = ALU_BTFSS;
    end else if (op_is(inst, M_GRP, V_MOVLW)) begin
      d.op = ALU_MOVLW; d.wr_w = 1'b1;
    end else if (op_is(inst, M_GRP, V_IORLW)) begin
      d.op = ALU_IORLW; d.wr_w = 1'b1; d.flg = FL_Z;
    end else if (op_is(inst, M_GRP, V_ANDLW)) begin
      d.op = ALU_ANDLW; d.wr_w = 1'b1; d.flg = FL_Z;
    end else if (op_is(inst, M_GRP, V_XORLW)) begin
      d.op = ALU_XORLW; d.wr_w = 1'b1; d.flg = FL_Z;
    end
    return d;
  endfunction

endpackage

// File: rtl/pic_exec_unit_alu.sv
// pic_alu: combinational ALU of the PIC16C57 execute stage.
// Ports:
//   op_i    operation class from the decoder
//   opnd_i  file operand, w_i W register, lit_i literal, bit_i bit index
//   c_i     carry in (STATUS.C) for the rotates
//   res_o   result; c_o / dc_o / z_o flags; skip_o skip condition
module pic_alu
  import pic_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = PIC_DATA_WIDTH
) (
  input  alu_op_e                       op_i,
  input  logic [DATA_WIDTH-1:0]         opnd_i,
  input  logic [DATA_WIDTH-1:0]         w_i,
  input  logic [DATA_WIDTH-1:0]         lit_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] bit_i,
  input  logic                          c_i,
  output logic [DATA_WIDTH-1:0]         res_o,
  output logic                          c_o,
  output logic                          dc_o,
  output logic                          z_o,
  output logic                          skip_o
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] bmask;

  always_comb begin
    bmask        = '0;
    bmask[bit_i] = 1'b1;
    sum          = '0;
    res_o        = opnd_i;
    c_o          = 1'b0;
    dc_o         = 1'b0;
    skip_o       = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        sum   = {1'b0, opnd_i} + {1'b0, w_i};
        res_o = sum[DATA_WIDTH-1:0];
        c_o   = sum[DATA_WIDTH];
        // carry into bit 4 recovered from the sum bit and the two addend bits
        dc_o  = sum[4] ^ opnd_i[4] ^ w_i[4];
      end
      ALU_SUB: begin
        // f - W as f + ~W + 1, so carry out means "no borrow"
        sum   = {1'b0, opnd_i} + {1'b0, ~w_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
        res_o = sum[DATA_WIDTH-1:0];
        c_o   = sum[DATA_WIDTH];
        dc_o  = sum[4] ^ opnd_i[4] ^ ~w_i[4];
      end
      ALU_DEC:    res_o = opnd_i - 1'b1;
      ALU_INC:    res_o = opnd_i + 1'b1;
      ALU_DECFSZ: begin
        res_o  = opnd_i - 1'b1;
        skip_o = (res_o == '0);
      end
      ALU_INCFSZ: begin
        res_o  = opnd_i + 1'b1;
        skip_o = (res_o == '0);
      end
      ALU_IOR:    res_o = opnd_i | w_i;
      ALU_AND:    res_o = opnd_i & w_i;
      ALU_XOR:    res_o = opnd_i ^ w_i;
      ALU_MOVF:   res_o = opnd_i;
      ALU_COMF:   res_o = ~opnd_i;
      ALU_CLR:    res_o = '0;
      ALU_MOVWF:  res_o = w_i;
      ALU_RRF: begin
        res_o = {c_i, opnd_i[DATA_WIDTH-1:1]};
        c_o   = opnd_i[0];
      end
      ALU_RLF: begin
        res_o = {opnd_i[DATA_WIDTH-2:0], c_i};
        c_o   = opnd_i[DATA_WIDTH-1];
      end
      ALU_SWAP:   res_o = {opnd_i[3:0], opnd_i[7:4]};
      ALU_BCF:    res_o = opnd_i & ~bmask;
      ALU_BSF:    res_o = opnd_i | bmask;
      ALU_BTFSC:  skip_o = ~|(opnd_i & bmask);
      ALU_BTFSS:  skip_o = |(opnd_i & bmask);
      ALU_MOVLW:  res_o = lit_i;
      ALU_IORLW:  res_o = lit_i | w_i;
      ALU_ANDLW:  res_o = lit_i & w_i;
      ALU_XORLW:  res_o = lit_i ^ w_i;
      default:    res_o = opnd_i;
    endcase
    z_o = (res_o == '0);
  end

endmodule

// File: rtl/pic_exec_unit.sv
// pic_exec_unit: PIC16C57 execute stage, one instruction per four Q-phases.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   instValid/instIn fetch handshake and instruction word; instReady high in Q1
//   regfileIn        file read data for rfFileAddr; statusRdIn current STATUS
//   rfWriteCommand   RF_WR_* command, valid in Q4 only
//   rfFileAddr       file address (inst[4:0]), valid Q2..Q4
//   rfWriteData      file write data (Q4); rfStatusOut new STATUS (Q4)
//   wOut             W register
//   skipNext         Q4 pulse: the following instruction is squashed
//   unsupported      Q4 pulse for opcodes not executed here
module pic_exec_unit
  import pic_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = PIC_DATA_WIDTH,
  parameter int INST_WIDTH = PIC_INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instValid,
  input  logic [INST_WIDTH-1:0] instIn,
  output logic                  instReady,
  input  logic [DATA_WIDTH-1:0] regfileIn,
  input  logic [DATA_WIDTH-1:0] statusRdIn,
  output logic [2:0]            rfWriteCommand,
  output logic [4:0]            rfFileAddr,
  output logic [DATA_WIDTH-1:0] rfWriteData,
  output logic [DATA_WIDTH-1:0] rfStatusOut,
  output logic [DATA_WIDTH-1:0] wOut,
  output logic                  skipNext,
  output logic                  unsupported
);

  qphase_e               phase_q, phase_d;
  logic [INST_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] w_q;
  logic                  squash_q;   // current instruction is skipped
  logic                  pend_q;     // skip requested for the next instruction
  logic [4:0]            addr_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] stat_q;
  logic [2:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] st_out_q, st_d;
  logic                  skipn_q;
  logic                  unsup_q;
  logic                  wr_w_q;

  dec_t                  dec;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c, alu_dc, alu_z, alu_skip;

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) phase_q <= Q1;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      Q1: phase_d = Q2;
      Q2: phase_d = Q3;
      Q3: phase_d = Q4;
      Q4: phase_d = Q1;
    endcase
  end

  always_comb begin
    instReady = (phase_q == Q1);
  end

  // ---------------- decode / ALU ----------------
  always_comb begin
    dec = decode(ir_q);
  end

  pic_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i   (dec.op),
    .opnd_i (opnd_q),
    .w_i    (w_q),
    .lit_i  (ir_q[DATA_WIDTH-1:0]),
    .bit_i  (ir_q[7:5]),
    .c_i    (stat_q[ST_C]),
    .res_o  (alu_res),
    .c_o    (alu_c),
    .dc_o   (alu_dc),
    .z_o    (alu_z),
    .skip_o (alu_skip)
  );

  // Q4 command and STATUS, built in Q3 and registered on the Q3 edge
  always_comb begin
    st_d = stat_q;
    if (dec.flg[ST_C])  st_d[ST_C]  = alu_c;
    if (dec.flg[ST_DC]) st_d[ST_DC] = alu_dc;
    if (dec.flg[ST_Z])  st_d[ST_Z]  = alu_z;

    cmd_d = RF_WR________NOP;
    if (dec.wr_f && (dec.flg != FL_NONE))      cmd_d = RF_WR_FSR_STATUS;
    else if (dec.wr_f)                         cmd_d = RF_WR_FSR____IND;
    else if (dec.wr_w && (dec.flg != FL_NONE)) cmd_d = RF_WR_____STATUS;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= INST_NOP;
      w_q      <= '0;
      squash_q <= 1'b0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      opnd_q   <= '0;
      stat_q   <= '0;
      cmd_q    <= RF_WR________NOP;
      data_q   <= '0;
      st_out_q <= '0;
      skipn_q  <= 1'b0;
      unsup_q  <= 1'b0;
      wr_w_q   <= 1'b0;
    end else begin
      unique case (phase_q)
        Q1: begin
          ir_q     <= instValid ? instIn : INST_NOP;
          addr_q   <= instValid ? instIn[4:0] : 5'd0;
          squash_q <= pend_q;
          pend_q   <= 1'b0;
        end
        Q2: begin
          opnd_q <= regfileIn;
          stat_q <= statusRdIn;
        end
        Q3: begin
          // a squashed instruction has no visible effect at all
          cmd_q    <= squash_q ? RF_WR________NOP : cmd_d;
          data_q   <= squash_q ? '0 : alu_res;
          st_out_q <= squash_q ? '0 : st_d;
          skipn_q  <= !squash_q && alu_skip;
          unsup_q  <= !squash_q && dec.unsup;
          wr_w_q   <= !squash_q && dec.wr_w;
        end
        Q4: begin
          if (wr_w_q) w_q <= data_q;
          pend_q   <= skipn_q;
          cmd_q    <= RF_WR________NOP;
          data_q   <= '0;
          st_out_q <= '0;
          skipn_q  <= 1'b0;
          unsup_q  <= 1'b0;
          wr_w_q   <= 1'b0;
          addr_q   <= '0;
        end
      endcase
    end
  end

  assign rfWriteCommand = cmd_q;
  assign rfFileAddr     = addr_q;
  assign rfWriteData    = data_q;
  assign rfStatusOut    = st_out_q;
  assign wOut           = w_q;
  assign skipNext       = skipn_q;
  assign unsupported    = unsup_q;

endmodule

// File: tb/tb_pic_exec_unit.sv
module tb_pic_exec_unit;
  import pic_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instValid;
  logic [11:0] instIn;
  logic        instReady;
  logic [7:0]  regfileIn;
  logic [7:0]  statusRdIn;
  logic [2:0]  rfWriteCommand;
  logic [4:0]  rfFileAddr;
  logic [7:0]  rfWriteData;
  logic [7:0]  rfStatusOut;
  logic [7:0]  wOut;
  logic        skipNext;
  logic        unsupported;

  pic_exec_unit dut (
    .clk(clk), .rst(rst), .instValid(instValid), .instIn(instIn),
    .instReady(instReady), .regfileIn(regfileIn), .statusRdIn(statusRdIn),
    .rfWriteCommand(rfWriteCommand), .rfFileAddr(rfFileAddr),
    .rfWriteData(rfWriteData), .rfStatusOut(rfStatusOut), .wOut(wOut),
    .skipNext(skipNext), .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] data;
    logic [7:0] st;
    logic       skip;
    logic       unsup;
    logic [7:0] w;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input logic [2:0] cmd, input logic [7:0] data,
                              input logic [7:0] st, input logic skip,
                              input logic unsup, input logic [7:0] w);
    exp_t e;
    e.cmd = cmd; e.data = data; e.st = st; e.skip = skip; e.unsup = unsup; e.w = w;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from a negedge in Q1 to the negedge of the next Q1.
  task automatic do_inst(input string nm, input logic v, input logic [11:0] inst,
                         input logic [7:0] f, input logic [7:0] st, input exp_t e);
    exp_t x;
    sb.push_back(e);
    instValid = v;
    instIn    = inst;
    chk({nm, ".ready"}, instReady, 1'b1);
    @(posedge clk); @(negedge clk);                  // Q2
    instValid = 1'b0;
    chk({nm, ".q2ready"}, instReady, 1'b0);
    if (v) chk({nm, ".addr"}, rfFileAddr, inst[4:0]);
    regfileIn  = f;
    statusRdIn = st;
    @(posedge clk); @(negedge clk);                  // Q3
    chk({nm, ".q3cmd"}, rfWriteCommand, RF_WR________NOP);
    @(posedge clk); @(negedge clk);                  // Q4
    x = sb.pop_front();
    chk({nm, ".cmd"}, rfWriteCommand, x.cmd);
    chk({nm, ".skip"}, skipNext, x.skip);
    chk({nm, ".unsup"}, unsupported, x.unsup);
    if (x.cmd != RF_WR________NOP) begin
      chk({nm, ".data"}, rfWriteData, x.data);
      chk({nm, ".status"}, rfStatusOut, x.st);
    end
    if (v) chk({nm, ".q4addr"}, rfFileAddr, inst[4:0]);
    @(posedge clk); @(negedge clk);                  // next Q1
    chk({nm, ".q1cmd"}, rfWriteCommand, RF_WR________NOP);
    chk({nm, ".q1skip"}, skipNext, 1'b0);
    chk({nm, ".q1unsup"}, unsupported, 1'b0);
    chk({nm, ".w"}, wOut, x.w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    instValid  = 1'b0;
    instIn     = '0;
    regfileIn  = '0;
    statusRdIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.cmd", rfWriteCommand, RF_WR________NOP);
    chk("rst.w", wOut, 8'h00);
    chk("rst.data", rfWriteData, 8'h00);
    chk("rst.status", rfStatusOut, 8'h00);
    chk("rst.addr", rfFileAddr, 5'h00);
    chk("rst.skip", skipNext, 1'b0);
    chk("rst.unsup", unsupported, 1'b0);
    rst = 1'b0;

    do_inst("movlw0f", 1'b1, 12'hC0F, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h0F));
    do_inst("addwf",   1'b1, 12'h1F0, 8'h01, 8'hA0, mk(RF_WR_FSR_STATUS, 8'h10, 8'hA2, 0, 0, 8'h0F));
    do_inst("movlw05", 1'b1, 12'hC05, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h05));
    do_inst("subwf",   1'b1, 12'h091, 8'h05, 8'hA0, mk(RF_WR_____STATUS, 8'h00, 8'hA7, 0, 0, 8'h00));
    do_inst("decfsz",  1'b1, 12'h2F2, 8'h01, 8'hA0, mk(RF_WR_FSR____IND, 8'h00, 8'hA0, 1, 0, 8'h00));
    do_inst("sq_movlw",1'b1, 12'hC55, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h00));
    do_inst("movlwaa", 1'b1, 12'hCAA, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'hAA));
    do_inst("btfss1",  1'b1, 12'h773, 8'h08, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 1, 0, 8'hAA));
    // squashed skip instruction must not skip the one after it
    do_inst("sq_btfss",1'b1, 12'h773, 8'h08, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'hAA));
    do_inst("movlw77", 1'b1, 12'hC77, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h77));
    do_inst("btfss0",  1'b1, 12'h773, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h77));
    do_inst("movlw3c", 1'b1, 12'hC3C, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h3C));
    do_inst("movwf",   1'b1, 12'h028, 8'h99, 8'h5B, mk(RF_WR_FSR____IND, 8'h3C, 8'h5B, 0, 0, 8'h3C));
    do_inst("bubble",  1'b0, 12'hC11, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h3C));
    do_inst("rlf",     1'b1, 12'h354, 8'h81, 8'h04, mk(RF_WR_____STATUS, 8'h02, 8'h05, 0, 0, 8'h02));
    do_inst("incf",    1'b1, 12'h2B5, 8'hFF, 8'h00, mk(RF_WR_FSR_STATUS, 8'h00, 8'h04, 0, 0, 8'h02));
    do_inst("goto",    1'b1, 12'hB23, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 1, 8'h02));

    // reset during Q3 of an ADDWF aborts it
    instValid = 1'b1;
    instIn    = 12'h1F0;
    @(posedge clk); @(negedge clk);                  // Q2
    instValid  = 1'b0;
    regfileIn  = 8'h01;
    statusRdIn = 8'hA0;
    @(posedge clk); @(negedge clk);                  // Q3
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rstq3.cmd", rfWriteCommand, RF_WR________NOP);
      chk("rstq3.w", wOut, 8'h00);
      chk("rstq3.ready", instReady, 1'b1);
    end
    rst = 1'b0;
    do_inst("post_rst", 1'b1, 12'hC12, 8'h00, 8'h00, mk(RF_WR________NOP, 8'h00, 8'h00, 0, 0, 8'h12));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
